// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared types and width helper for the button debounce bank
package btn_pkg;

  typedef struct packed {
    logic press;
    logic rel;
    logic lng;
  } btn_evt_t;

  // Counter width able to hold 0..max_val, never narrower than one bit
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// rtl/btn_debounce_ch.sv - one channel: synchroniser, debounce counter, hold counter, pulses
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int   DEBOUNCE_CYC = 250000,
  parameter int   LONG_CYC     = 0,
  parameter logic INV          = 1'b0
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  input  logic     raw,
  output logic     state,
  output btn_evt_t evt
);

  localparam int            CW      = cnt_width(DEBOUNCE_CYC);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync_a;
  logic          sync_b;
  logic          s;
  logic [CW-1:0] cnt;
  logic          press;
  logic          rel;
  logic          lng;

  // Sync FFs idle at the inactive pad level so reset never looks like a press
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_a <= INV;
      sync_b <= INV;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  assign s = sync_b ^ INV;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt   <= '0;
      state <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      press <= 1'b0;
      rel   <= 1'b0;
      if (s == state) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        state <= s;
        cnt   <= '0;
        press <= s;
        rel   <= ~s;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  if (LONG_CYC > 0) begin : g_hold
    localparam int            HW        = cnt_width(LONG_CYC);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYC);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYC - 1);

    logic [HW-1:0] hold;

    // Saturating at HOLD_MAX is what keeps the long pulse to a single cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        hold <= '0;
        lng  <= 1'b0;
      end else if (!state) begin
        hold <= '0;
        lng  <= 1'b0;
      end else begin
        lng <= (hold == HOLD_LAST);
        if (hold != HOLD_MAX) begin
          hold <= hold + HW'(1);
        end
      end
    end
  end else begin : g_no_hold
    assign lng = 1'b0;
  end

  assign evt = {press, rel, lng};

endmodule

// File: rtl/btn_debounce_bank.sv
// rtl/btn_debounce_bank.sv - bank of debounced button channels with sticky W1C events and irq
module btn_debounce_bank
  import btn_pkg::*;
#(
  parameter int                 NUM_BTN      = 6,
  parameter int                 DEBOUNCE_CYC = 250000,
  parameter int                 LONG_CYC     = 0,
  parameter logic [NUM_BTN-1:0] BTN_INV      = NUM_BTN'(1)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_state,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] rel_pulse,
  output logic [NUM_BTN-1:0] long_pulse,
  output logic [NUM_BTN-1:0] evt_press,
  output logic [NUM_BTN-1:0] evt_long,
  input  logic [NUM_BTN-1:0] evt_clr,
  input  logic [NUM_BTN-1:0] irq_en,
  output logic               irq
);

  logic [NUM_BTN-1:0] press_nxt;
  logic [NUM_BTN-1:0] long_nxt;

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_ch
    btn_evt_t ch_evt;

    btn_debounce_ch #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .LONG_CYC     (LONG_CYC),
      .INV          (BTN_INV[gi])
    ) u_ch (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .raw     (btn_raw[gi]),
      .state   (btn_state[gi]),
      .evt     (ch_evt)
    );

    assign press_pulse[gi] = ch_evt.press;
    assign rel_pulse[gi]   = ch_evt.rel;
    assign long_pulse[gi]  = ch_evt.lng;
  end

  // Set is ORed in after the clear so a coincident clear never loses an event
  always_comb begin
    press_nxt = (evt_press & ~evt_clr) | press_pulse;
    long_nxt  = (evt_long  & ~evt_clr) | long_pulse;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      evt_press <= '0;
      evt_long  <= '0;
      irq       <= 1'b0;
    end else begin
      evt_press <= press_nxt;
      evt_long  <= long_nxt;
      irq       <= |((press_nxt | long_nxt) & irq_en);
    end
  end

endmodule
